// File: rtl/boreal_safety_supervisor_if.sv
// Sample, control and status bundle between the safety supervisor and its host.
// The master drives samples and operator controls; the slave (supervisor) returns status.
interface boreal_safety_supervisor_if;
  logic        valid;
  logic [3:0]  flags;
  logic        arm;
  logic        clear_req;
  logic        output_enable;
  logic [1:0]  state;
  logic [3:0]  fault_latch;
  logic [15:0] fault_count;
  logic        irq;

  modport master (
    output valid, flags, arm, clear_req,
    input  output_enable, state, fault_latch, fault_count, irq
  );

  modport slave (
    input  valid, flags, arm, clear_req,
    output output_enable, state, fault_latch, fault_count, irq
  );
endinterface

// File: rtl/boreal_safety_supervisor.sv
// Artifact-flag safety supervisor: debounces sensor flags, latches faults and gates the
// downstream path until an operator clear and a clean recovery window have been seen.
module boreal_safety_supervisor #(
  parameter logic [7:0]  DEBOUNCE       = 8'd3,
  parameter logic [15:0] CLEAN_LIMIT    = 16'd16,
  parameter logic [3:0]  IMMEDIATE_MASK = 4'b1001
) (
  input logic                       clk,
  input logic                       rst_n,
  boreal_safety_supervisor_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StFault   = 2'd2,
    StRecover = 2'd3
  } state_e;

  state_e      r_state;
  logic [7:0]  r_deb [4];
  logic [3:0]  r_latch;
  logic [15:0] r_fault_cnt;
  logic [15:0] r_clean;
  logic        r_irq;

  logic [3:0]  w_trip;
  logic [7:0]  w_deb_next [4];
  logic        w_all_imm;
  logic [15:0] w_clean_inc;
  logic        w_clean_done;

  // A debounce of 0 or 1 degenerates to single-sample tripping on every bit.
  assign w_all_imm    = (DEBOUNCE <= 8'd1);
  assign w_clean_inc  = r_clean + 16'd1;
  assign w_clean_done = (w_clean_inc >= CLEAN_LIMIT);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_trip[i] = bus.valid && bus.flags[i] &&
                  (IMMEDIATE_MASK[i] || w_all_imm || (r_deb[i] == DEBOUNCE - 8'd1));
      if (!bus.flags[i]) begin
        w_deb_next[i] = 8'd0;
      end else if (r_deb[i] >= DEBOUNCE) begin
        w_deb_next[i] = DEBOUNCE;
      end else begin
        w_deb_next[i] = r_deb[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_latch     <= 4'd0;
      r_fault_cnt <= 16'd0;
      r_clean     <= 16'd0;
      r_irq       <= 1'b0;
      for (int i = 0; i < 4; i++) r_deb[i] <= 8'd0;
    end else begin
      r_irq <= 1'b0;
      case (r_state)
        StIdle: begin
          if (bus.arm) begin
            r_state <= StArmed;
            for (int i = 0; i < 4; i++) r_deb[i] <= 8'd0;
          end
        end
        StArmed: begin
          if (bus.valid) begin
            for (int i = 0; i < 4; i++) r_deb[i] <= w_deb_next[i];
          end
          // A trip takes priority over a simultaneous disarm.
          if (|w_trip) begin
            r_state <= StFault;
            r_latch <= r_latch | w_trip;
            r_irq   <= 1'b1;
            if (r_fault_cnt != 16'hFFFF) r_fault_cnt <= r_fault_cnt + 16'd1;
          end else if (!bus.arm) begin
            r_state <= StIdle;
          end
        end
        StFault: begin
          if (bus.clear_req) begin
            r_state <= StRecover;
            r_clean <= 16'd0;
          end
        end
        StRecover: begin
          if (bus.valid) begin
            if (bus.flags != 4'd0) begin
              r_clean <= 16'd0;
            end else if (w_clean_done) begin
              r_state <= bus.arm ? StArmed : StIdle;
              r_latch <= 4'd0;
              r_clean <= 16'd0;
              for (int i = 0; i < 4; i++) r_deb[i] <= 8'd0;
            end else begin
              r_clean <= w_clean_inc;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.output_enable = (r_state == StArmed);
  assign bus.state         = r_state;
  assign bus.fault_latch   = r_latch;
  assign bus.fault_count   = r_fault_cnt;
  assign bus.irq           = r_irq;

endmodule
